flash_burst_sequencer: RTL and testbench
========================================

// Module: flash_burst_sequencer
// PURPOSE
//  Parametrised SPI-flash exercise sequencer: issues single commands, write bursts and read-back-check
//  bursts against the flash controller's cmd/data handshakes. Sits between board triggers (pre-synchronised
//  pulses) and the flash controller. Adds selectable op/length/pattern, read compare, error count, status.
// PARAMETERS
//  DATA_W     8          data beat width
//  CMD_W      8          command code width
//  LEN_W      12         burst length field width (max burst 2**LEN_W-1 beats)
//  FRAME_TKS  3          clk_en ticks rd/wr_frame_flag is held before the data phase
//  WR_DELAY   24'hFF0000 clock cycles of post-write settle wait (0 = skip wait)
//  SEED       8'h01      pattern start value (bit-sliced/zero-extended to DATA_W)
// PORTS
//  clock          in   1       system clock
//  rst            in   1       asynchronous reset, active-high
//  clk_en         in   1       SPI bit-rate enable; all handshakes/state advances qualified by it
//  start          in   1       1-cycle pulse: launch op
//  op             in   2       0=CMD 1=WRITE 2=READ_CHK 3=reserved
//  cmd_code       in   CMD_W   command issued by op CMD
//  burst_len      in   LEN_W   beats per burst; sampled on accepted start
//  cmd_request    out  1       command request to controller
//  cmd            out  CMD_W   command value
//  wr_frame_flag  out  1       write frame open
//  rd_frame_flag  out  1       read frame open
//  wr_valid       out  1       write beat valid
//  wr_data        out  DATA_W  write beat data
//  wr_ready       in   1       controller accepts write beat
//  rd_valid       in   1       read beat valid
//  rd_data        in   DATA_W  read beat data
//  rd_ready       out  1       sequencer accepts read beat
//  busy           out  1       state != IDLE
//  done           out  1       1-cycle pulse at op completion
//  err_cnt        out  16      read mismatches in last READ_CHK, saturating at 16'hFFFF
//  first_err_idx  out  LEN_W   beat index of first mismatch (valid when err_cnt != 0)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pattern = SEED. Reset mid-op aborts immediately, no done.
//  Beat transfer = valid && ready && clk_en (both directions). Registered outputs; 1-cycle latency from state.
//  FSM: IDLE -start&&op!=3-> CMD_REQ(op0) | FRAME(op1,2). start while busy, op==3, burst_len==0: ignored.
//   CMD_REQ: cmd_request=1, cmd=cmd_code, held 2 clk_en ticks -> FSH.
//   FRAME: wr_/rd_frame_flag=1 for FRAME_TKS clk_en ticks -> WAIT_RDY(op1) | BURST_RD(op2).
//   WAIT_RDY: wr_ready && clk_en -> BURST_WR.
//   BURST_WR: wr_valid=1; wr_data = pattern, advanced per transfer; beat cnt==burst_len -> FSH.
//   BURST_RD: rd_ready=1; per transfer compare rd_data vs expected pattern, advance; cnt==burst_len -> FSH.
//   FSH: done=1 for one cycle -> WAIT_DLY (op1, WR_DELAY!=0) else IDLE. WAIT_DLY: count WR_DELAY clocks,
//   unqualified by clk_en -> IDLE; busy stays 1 throughout.
//  Last beat: valid/ready deassert the cycle after final transfer; no extra beat. Beat cnt is LEN_W wide.
//  err_cnt/first_err_idx cleared on READ_CHK start; held until next READ_CHK; saturate, never wrap.
//  clk_en low freezes every counter and handshake except WAIT_DLY.
// CONFIGURATION
//  FLASH_SEQ_PRBS_EN defined: pattern = LFSR x^8+x^6+x^5+x^4+1 (Galois, shift left, low 8 bits, zero-ext to DATA_W),
//   seeded SEED (SEED=0 forced to 1). Undefined: pattern = incrementing counter from SEED, wraps mod 2**DATA_W.
//  Write generator and read checker use the identical sequence from the same seed.
// STRUCTURE
//  flash_seq_pkg: op_t enum (OP_CMD, OP_WRITE, OP_READ_CHK), state_t enum, LFSR tap constant.
//  Sub-module flash_seq_pattern_gen (load/advance/value), instanced twice: write source, read expected.
// TESTING
//  op=CMD cmd_code=8'h06, clk_en every 4th clk -> cmd_request high 2 ticks, cmd=06, one done, busy drops.
//  op=WRITE len=16, wr_ready=1, WR_DELAY=20 -> beats 01..10 (counter), done, busy low 20 clks later.
//  op=READ_CHK len=16, model returns 01..10 with beat 5 = 8'hFF -> err_cnt=1, first_err_idx=5.
//  Random wr_ready/rd_valid stalls, clk_en duty 1/3 -> exactly len beats, in order, no dup/drop.
//  start during BURST_WR and op=3 -> ignored; rst pulse mid-BURST_RD -> all outputs 0, no done.
//  FLASH_SEQ_PRBS_EN, SEED=1, len=4 WRITE -> 01,02,04,08; READ_CHK of same -> err_cnt=0.

Source files
------------

// File: rtl/flash_seq_pkg.sv
// Shared types and constants for the flash burst sequencer.
// The LFSR helper is used only when FLASH_SEQ_PRBS_EN is defined.
package flash_seq_pkg;

  typedef enum logic [1:0] {
    OP_CMD      = 2'd0,
    OP_WRITE    = 2'd1,
    OP_READ_CHK = 2'd2,
    OP_RSVD     = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    StIdle,
    StCmdReq,
    StFrame,
    StWaitRdy,
    StBurstWr,
    StBurstRd,
    StFsh,
    StWaitDly
  } state_t;

  // Galois taps for x^8+x^6+x^5+x^4+1 (bits 6,5,4,0), shift-left form
  localparam logic [7:0]  LFSR_TAPS = 8'h71;
  localparam int unsigned CMD_TKS   = 2;
  localparam int unsigned TICK_W    = 8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/flash_seq_pattern_gen.sv
// Test pattern source: reloads SEED on i_load, steps on i_advance.
// FLASH_SEQ_PRBS_EN defined: 8-bit Galois LFSR, zero-extended to DATA_W.
// Undefined: incrementing counter from SEED, wrapping mod 2**DATA_W.
module flash_seq_pattern_gen
  import flash_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter logic [7:0]  SEED   = 8'h01
) (
  input  logic              i_clock,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_advance,
  output logic [DATA_W-1:0] o_value
);

`ifdef FLASH_SEQ_PRBS_EN
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1
  localparam logic [7:0] SEED8 = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] r_lfsr;

  // LFSR state: reload or step
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= SEED8;
    end else if (i_load) begin
      r_lfsr <= SEED8;
    end else if (i_advance) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = DATA_W'(r_lfsr);
`else
  localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);

  logic [DATA_W-1:0] r_count;

  // Counter state: reload or increment
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_count <= SEED_W;
    end else if (i_load) begin
      r_count <= SEED_W;
    end else if (i_advance) begin
      r_count <= r_count + DATA_W'(1);
    end
  end

  assign o_value = r_count;
`endif

endmodule

// File: rtl/flash_burst_sequencer.sv
// SPI-flash exercise sequencer: single commands, write bursts and read-back-check bursts.
// Pattern source selected by FLASH_SEQ_PRBS_EN (LFSR) or counter (default).
// Outputs are flops loaded from the next state, so they line up with the state register.
module flash_burst_sequencer
  import flash_seq_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CMD_W     = 8,
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned FRAME_TKS = 3,
  parameter logic [23:0] WR_DELAY  = 24'hFF0000,
  parameter logic [7:0]  SEED      = 8'h01
) (
  input  logic              i_clock,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [CMD_W-1:0]  i_cmd_code,
  input  logic [LEN_W-1:0]  i_burst_len,
  output logic              o_cmd_request,
  output logic [CMD_W-1:0]  o_cmd,
  output logic              o_wr_frame_flag,
  output logic              o_rd_frame_flag,
  output logic              o_wr_valid,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic              i_wr_ready,
  input  logic              i_rd_valid,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_rd_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_err_cnt,
  output logic [LEN_W-1:0]  o_first_err_idx
);

  state_t            r_state, w_state_d;
  op_t               r_op, w_op_d;
  logic [LEN_W-1:0]  r_len, w_len_d;
  logic [LEN_W-1:0]  r_beat_cnt, w_beat_d, w_beat_inc;
  logic [TICK_W-1:0] r_tick_cnt, w_tick_d;
  logic [23:0]       r_dly_cnt, w_dly_d;

  logic              r_cmd_request, r_wr_frame, r_rd_frame, r_wr_valid, r_rd_ready;
  logic              r_busy, r_done;
  logic [CMD_W-1:0]  r_cmd;
  logic [15:0]       r_err_cnt;
  logic [LEN_W-1:0]  r_first_err_idx;

  logic              w_accept, w_wr_xfer, w_rd_xfer, w_cmd_last, w_frame_last, w_dly_last;
  logic [DATA_W-1:0] w_wr_pat, w_exp_pat;

  // Start is a board trigger, so it is accepted on any clock, not only on clk_en ticks
  assign w_accept     = (r_state == StIdle) && i_start && (op_t'(i_op) != OP_RSVD) &&
                        (i_burst_len != '0);
  assign w_wr_xfer    = r_wr_valid && i_wr_ready && i_clk_en;
  assign w_rd_xfer    = r_rd_ready && i_rd_valid && i_clk_en;
  assign w_beat_inc   = r_beat_cnt + LEN_W'(1);
  assign w_cmd_last   = (32'(r_tick_cnt) + 32'd1) >= CMD_TKS;
  assign w_frame_last = (32'(r_tick_cnt) + 32'd1) >= FRAME_TKS;
  assign w_dly_last   = (r_dly_cnt == WR_DELAY - 24'd1);

  flash_seq_pattern_gen #(
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_wr_pat (
    .i_clock   (i_clock),
    .i_rst     (i_rst),
    .i_load    (w_accept),
    .i_advance (w_wr_xfer),
    .o_value   (w_wr_pat)
  );

  flash_seq_pattern_gen #(
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_exp_pat (
    .i_clock   (i_clock),
    .i_rst     (i_rst),
    .i_load    (w_accept),
    .i_advance (w_rd_xfer),
    .o_value   (w_exp_pat)
  );

  // Next-state and counter logic
  always_comb begin
    w_state_d = r_state;
    w_op_d    = r_op;
    w_len_d   = r_len;
    w_beat_d  = r_beat_cnt;
    w_tick_d  = r_tick_cnt;
    w_dly_d   = r_dly_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_op_d    = op_t'(i_op);
          w_len_d   = i_burst_len;
          w_beat_d  = '0;
          w_tick_d  = '0;
          w_state_d = (op_t'(i_op) == OP_CMD) ? StCmdReq : StFrame;
        end
      end
      StCmdReq: begin
        if (i_clk_en) begin
          if (w_cmd_last) begin
            w_tick_d  = '0;
            w_state_d = StFsh;
          end else begin
            w_tick_d = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      StFrame: begin
        if (i_clk_en) begin
          if (w_frame_last) begin
            w_tick_d  = '0;
            w_state_d = (r_op == OP_WRITE) ? StWaitRdy : StBurstRd;
          end else begin
            w_tick_d = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      StWaitRdy: begin
        if (i_clk_en && i_wr_ready) w_state_d = StBurstWr;
      end
      StBurstWr: begin
        if (w_wr_xfer) begin
          w_beat_d = w_beat_inc;
          if (w_beat_inc == r_len) w_state_d = StFsh;
        end
      end
      StBurstRd: begin
        if (w_rd_xfer) begin
          w_beat_d = w_beat_inc;
          if (w_beat_inc == r_len) w_state_d = StFsh;
        end
      end
      StFsh: begin
        // Done lasts exactly one clock regardless of clk_en
        if ((r_op == OP_WRITE) && (WR_DELAY != 24'd0)) begin
          w_dly_d   = '0;
          w_state_d = StWaitDly;
        end else begin
          w_state_d = StIdle;
        end
      end
      StWaitDly: begin
        // Settle wait runs on raw clocks, not clk_en ticks
        if (w_dly_last) w_state_d = StIdle;
        else            w_dly_d   = r_dly_cnt + 24'd1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and counter registers
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_op       <= OP_CMD;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_tick_cnt <= '0;
      r_dly_cnt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_op       <= w_op_d;
      r_len      <= w_len_d;
      r_beat_cnt <= w_beat_d;
      r_tick_cnt <= w_tick_d;
      r_dly_cnt  <= w_dly_d;
    end
  end

  // Registered handshake/status outputs decoded from the next state
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_cmd_request <= 1'b0;
      r_cmd         <= '0;
      r_wr_frame    <= 1'b0;
      r_rd_frame    <= 1'b0;
      r_wr_valid    <= 1'b0;
      r_rd_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_cmd_request <= (w_state_d == StCmdReq);
      r_cmd         <= (w_state_d == StCmdReq) ? (w_accept ? i_cmd_code : r_cmd) : '0;
      // Frame stays open from the lead-in through the whole data phase
      r_wr_frame    <= (w_op_d == OP_WRITE) && (w_state_d inside {StFrame, StWaitRdy, StBurstWr});
      r_rd_frame    <= (w_op_d == OP_READ_CHK) && (w_state_d inside {StFrame, StBurstRd});
      r_wr_valid    <= (w_state_d == StBurstWr);
      r_rd_ready    <= (w_state_d == StBurstRd);
      r_busy        <= (w_state_d != StIdle);
      r_done        <= (w_state_d == StFsh);
    end
  end

  // Read-compare error tracking, cleared when a READ_CHK launches
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_err_cnt       <= '0;
      r_first_err_idx <= '0;
    end else if (w_accept && (op_t'(i_op) == OP_READ_CHK)) begin
      r_err_cnt       <= '0;
      r_first_err_idx <= '0;
    end else if (w_rd_xfer && (i_rd_data != w_exp_pat)) begin
      if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      if (r_err_cnt == 16'd0)    r_first_err_idx <= r_beat_cnt;
    end
  end

  assign o_cmd_request   = r_cmd_request;
  assign o_cmd           = r_cmd;
  assign o_wr_frame_flag = r_wr_frame;
  assign o_rd_frame_flag = r_rd_frame;
  assign o_wr_valid      = r_wr_valid;
  // Data bus is held at zero outside beats so idle/reset outputs read as 0
  assign o_wr_data       = r_wr_valid ? w_wr_pat : '0;
  assign o_rd_ready      = r_rd_ready;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_flash_burst_sequencer.sv
// Directed bench for flash_burst_sequencer (WR_DELAY=20, SEED=1, FRAME_TKS=3).
// Expected data follows FLASH_SEQ_PRBS_EN the same way the design does.
`timescale 1ns/1ps
module tb_flash_burst_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CMD_W  = 8;
  localparam int unsigned LEN_W  = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clk_en = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        op = 2'd0;
  logic [CMD_W-1:0]  cmd_code = '0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic              wr_ready = 1'b0;
  logic              rd_valid = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              cmd_request, wr_frame_flag, rd_frame_flag, wr_valid, rd_ready;
  logic              busy, done;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       err_cnt;
  logic [LEN_W-1:0]  first_err_idx;

  int total = 0;
  int bad   = 0;

  int          en_div = 1;
  bit          stall  = 1'b0;
  int          cyc    = 0;
  int          ri;
  logic [7:0]  rd_vals [16];
  int          rd_idx  = 0;
  int          rd_base = 0;
  int          done_cnt  = 0;
  int          cmd_ticks = 0;
  logic [7:0]  wr_log [$];

  flash_burst_sequencer #(
    .DATA_W    (DATA_W),
    .CMD_W     (CMD_W),
    .LEN_W     (LEN_W),
    .FRAME_TKS (3),
    .WR_DELAY  (24'd20),
    .SEED      (8'h01)
  ) dut (
    .i_clock         (clk),
    .i_rst           (rst),
    .i_clk_en        (clk_en),
    .i_start         (start),
    .i_op            (op),
    .i_cmd_code      (cmd_code),
    .i_burst_len     (burst_len),
    .o_cmd_request   (cmd_request),
    .o_cmd           (cmd),
    .o_wr_frame_flag (wr_frame_flag),
    .o_rd_frame_flag (rd_frame_flag),
    .o_wr_valid      (wr_valid),
    .o_wr_data       (wr_data),
    .i_wr_ready      (wr_ready),
    .i_rd_valid      (rd_valid),
    .i_rd_data       (rd_data),
    .o_rd_ready      (rd_ready),
    .o_busy          (busy),
    .o_done          (done),
    .o_err_cnt       (err_cnt),
    .o_first_err_idx (first_err_idx)
  );

  always #5 clk = ~clk;

  // Controller/flash model: drives enable and handshakes on the falling edge
  always @(negedge clk) begin
    cyc++;
    clk_en   = ((cyc % en_div) == 0);
    wr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    rd_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    ri       = rd_idx - rd_base;
    rd_data  = (ri >= 0 && ri < 16) ? rd_vals[ri] : 8'h00;
  end

  // Observe pre-edge values at each rising edge
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (cmd_request && clk_en) cmd_ticks++;
    if (wr_valid && wr_ready && clk_en) wr_log.push_back(wr_data);
    if (rd_ready && rd_valid && clk_en) rd_idx++;
  end

  initial begin
    #400us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int i);
    logic [7:0] s;
    s = 8'h01;
    for (int k = 0; k < i; k++) begin
`ifdef FLASH_SEQ_PRBS_EN
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
`else
      s = s + 8'd1;
`endif
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [LEN_W-1:0] len, input logic [7:0] c);
    op        = o;
    burst_len = len;
    cmd_code  = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int k;
    k = 0;
    while (!done && k < maxc) begin
      tick();
      k++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k;
    k = 0;
    while (busy && k < maxc) begin
      tick();
      k++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int c0, d0, w0, r0, n, k;
    for (int i = 0; i < 16; i++) rd_vals[i] = pat(i);

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst cmd_request", 32'(cmd_request), 32'd0);
    check("rst wr_valid/data", {23'd0, wr_valid, wr_data}, 32'd0);
    check("rst rd_ready/frames", {29'd0, rd_ready, wr_frame_flag, rd_frame_flag}, 32'd0);
    check("rst err", {4'd0, err_cnt, first_err_idx}, 32'd0);
    rst = 1'b0;
    tick();

    // Single command, clk_en every 4th clock
    en_div = 4;
    c0 = cmd_ticks;
    d0 = done_cnt;
    launch(2'd0, 12'd1, 8'h06);
    check("cmd request", 32'(cmd_request), 32'd1);
    check("cmd value", 32'(cmd), 32'h06);
    check("cmd busy", 32'(busy), 32'd1);
    wait_idle("cmd", 200);
    check("cmd ticks", 32'(cmd_ticks - c0), 32'd2);
    check("cmd done count", 32'(done_cnt - d0), 32'd1);
    check("cmd after", {23'd0, cmd_request, cmd}, 32'd0);

    // 16-beat write, always ready, then 20-clock settle
    en_div = 1;
    stall  = 1'b0;
    w0 = wr_log.size();
    d0 = done_cnt;
    launch(2'd1, 12'd16, 8'h00);
    check("wr16 frame", 32'(wr_frame_flag), 32'd1);
    wait_done("wr16", 200);
    n = 0;
    tick();
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("wr16 settle clocks", 32'(n), 32'd20);
    check("wr16 beats", 32'(wr_log.size() - w0), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("wr16 beat%0d", i), 32'(wr_log[w0+i]), 32'(pat(i)));
    check("wr16 done count", 32'(done_cnt - d0), 32'd1);
    check("wr16 valid low", 32'(wr_valid), 32'd0);

    // 16-beat read-check with one corrupted beat at index 5
    rd_vals[5] = 8'hFF;
    rd_base = rd_idx;
    launch(2'd2, 12'd16, 8'h00);
    check("rd16 frame", 32'(rd_frame_flag), 32'd1);
    wait_done("rd16", 200);
    tick();
    check("rd16 no settle", 32'(busy), 32'd0);
    check("rd16 beats", 32'(rd_idx - rd_base), 32'd16);
    check("rd16 err_cnt", 32'(err_cnt), 32'd1);
    check("rd16 first_err_idx", 32'(first_err_idx), 32'd5);
    check("rd16 ready low", 32'(rd_ready), 32'd0);
    rd_vals[5] = pat(5);

    // Short write/read of 4 beats (01,02,04,08 with LFSR)
    w0 = wr_log.size();
    launch(2'd1, 12'd4, 8'h00);
    wait_done("wr4", 100);
    wait_idle("wr4", 100);
    check("wr4 beats", 32'(wr_log.size() - w0), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("wr4 beat%0d", i), 32'(wr_log[w0+i]), 32'(pat(i)));
    rd_base = rd_idx;
    launch(2'd2, 12'd4, 8'h00);
    wait_done("rd4", 100);
    wait_idle("rd4", 100);
    check("rd4 err_cnt cleared", 32'(err_cnt), 32'd0);

    // Random stalls with clk_en duty 1/3
    en_div = 3;
    stall  = 1'b1;
    w0 = wr_log.size();
    launch(2'd1, 12'd10, 8'h00);
    wait_done("wrst", 800);
    wait_idle("wrst", 200);
    check("wrst beats", 32'(wr_log.size() - w0), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("wrst beat%0d", i), 32'(wr_log[w0+i]), 32'(pat(i)));
    rd_base = rd_idx;
    launch(2'd2, 12'd10, 8'h00);
    wait_done("rdst", 800);
    wait_idle("rdst", 200);
    check("rdst beats", 32'(rd_idx - rd_base), 32'd10);
    check("rdst err_cnt", 32'(err_cnt), 32'd0);

    // Start during a write burst, op=3 and zero length are all ignored
    en_div = 1;
    w0 = wr_log.size();
    d0 = done_cnt;
    launch(2'd1, 12'd8, 8'h00);
    k = 0;
    while (!wr_valid && k < 100) begin
      tick();
      k++;
    end
    check("ign in burst", 32'(wr_valid), 32'd1);
    launch(2'd2, 12'd5, 8'h00);
    check("ign no read frame", 32'(rd_frame_flag), 32'd0);
    wait_done("ign", 400);
    wait_idle("ign", 200);
    repeat (3) tick();
    check("ign beats", 32'(wr_log.size() - w0), 32'd8);
    check("ign done count", 32'(done_cnt - d0), 32'd1);
    launch(2'd3, 12'd4, 8'h00);
    check("op3 ignored", 32'(busy), 32'd0);
    launch(2'd1, 12'd0, 8'h00);
    check("len0 ignored", 32'(busy), 32'd0);

    // Reset pulse in the middle of a read burst
    en_div = 2;
    rd_base = rd_idx;
    launch(2'd2, 12'd16, 8'h00);
    k = 0;
    while (!rd_ready && k < 100) begin
      tick();
      k++;
    end
    check("rrst in burst", 32'(rd_ready), 32'd1);
    r0 = rd_idx;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rrst busy", 32'(busy), 32'd0);
    check("rrst rd_ready/frame", {30'd0, rd_ready, rd_frame_flag}, 32'd0);
    check("rrst done/err", {15'd0, done, err_cnt}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rrst no done", 32'(done_cnt - d0), 32'd0);
    check("rrst stays idle", 32'(busy), 32'd0);
    check("rrst no beats", 32'(rd_idx - r0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
